// File: rtl/rv_core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_core_pkg
// Description : Shared constants and pipeline-register types for the RV32I
//               single-issue core front end.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_core_pkg;

  localparam int              XLEN             = 32;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013; // addi x0, x0, 0
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // IF/ID pipeline register contents; decode consumes the same type.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } if_id_t;

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register. Load captures a fetched word, flush
//               invalidates the slot while keeping its payload, otherwise hold.
//               Resets to an invalid NOP at address 0.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
  import rv_core_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_in,
  output if_id_t          entry
);

  if_id_t r_entry;

  // Flush wins over load so a squashed wrong-path word never becomes valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entry.valid <= 1'b0;
      r_entry.instr <= NOP_INSTR;
      r_entry.pc    <= '0;
    end else if (flush) begin
      r_entry.valid <= 1'b0;
    end else if (load) begin
      r_entry.valid <= 1'b1;
      r_entry.instr <= instr_in;
      r_entry.pc    <= pc_in;
    end
  end

  assign entry = r_entry;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Fetch stage. Owns the PC, addresses the combinational
//               instruction memory, registers the word into IF/ID and hands
//               it to decode under valid/ready. Redirects squash the slot.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit
  import rv_core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic [XLEN-1:0] fetch_count
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_fetch_count;
  if_id_t          w_if_id;
  logic            w_advance;
  logic            w_handshake;
  logic            w_load;
  logic [XLEN-1:0] w_redirect_target;

  // Slot is empty or being drained this cycle, so a new word may enter.
  assign w_advance         = !w_if_id.valid || id_ready;
  assign w_handshake       = w_if_id.valid && id_ready;
  assign w_load            = w_advance && !redirect_valid;
  // Targets are word aligned; low address bits are dropped.
  assign w_redirect_target = redirect_pc & ~(XLEN'(3));

  // Program counter: redirect beats sequential advance; a stall holds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= w_redirect_target;
    end else if (w_advance) begin
      r_pc <= r_pc + XLEN'(4);
    end
  end

  // Counts decode handshakes, including one completing alongside a redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count <= '0;
    end else if (w_handshake) begin
      r_fetch_count <= r_fetch_count + XLEN'(1);
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .flush    (redirect_valid),
    .instr_in (imem_rdata),
    .pc_in    (r_pc),
    .entry    (w_if_id)
  );

  assign imem_addr   = r_pc;
  assign id_valid    = w_if_id.valid;
  assign id_instr    = w_if_id.instr;
  assign id_pc       = w_if_id.pc;
  assign id_pc_plus4 = w_if_id.pc + XLEN'(4);
  assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire
